// File: rtl/serial_byte_rx.sv
// Serial byte receiver with comma-based byte alignment.
// Bits arrive MSB first. A comma symbol (COM) marks a candidate byte boundary. LOCK_COUNT
// consecutive aligned commas lock the receiver. Once locked, every non-comma byte is
// presented on data_out with a one-cycle valid_out strobe. Comma bytes are treated as idle.
module serial_byte_rx #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int unsigned CntW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [CntW-1:0] LockCnt = CntW'(LOCK_COUNT);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);

    typedef enum logic [1:0] {StSearch, StSync, StActive} state_e;

    state_e          state_q;
    logic [7:0]      sr_q;
    logic [7:0]      sr_d;
    logic [2:0]      bit_cnt_q;
    logic [CntW-1:0] com_cnt_q;
    logic [CntW-1:0] com_cnt_inc;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            active_q;
    logic            is_com;
    logic            boundary;

    // Next shift-register value and the per-edge decode of the byte it holds.
    always_comb begin
        sr_d        = {sr_q[6:0], data_in};
        is_com      = (sr_d == COM);
        boundary    = (bit_cnt_q == 3'd7);
        com_cnt_inc = (com_cnt_q == LockCnt) ? com_cnt_q : com_cnt_q + OneCnt;
    end

    // Alignment FSM. It also registers the shift register, the counters and all outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StSearch;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            valid_q <= 1'b0;
            unique case (state_q)
                StSearch: begin
                    // Any bit position can start a byte here, so the bit counter is not used.
                    if (is_com) begin
                        bit_cnt_q <= 3'd0;
                        com_cnt_q <= OneCnt;
                        if (LOCK_COUNT <= 1) begin
                            state_q  <= StActive;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= StSync;
                        end
                    end
                end
                StSync: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt_q <= com_cnt_inc;
                            if (com_cnt_inc == LockCnt) begin
                                state_q  <= StActive;
                                active_q <= 1'b1;
                            end
                        end else begin
                            // Alignment was wrong. Drop the byte and hunt again.
                            state_q   <= StSearch;
                            com_cnt_q <= '0;
                        end
                    end
                end
                StActive: begin
                    // Locked for good. Only reset leaves this state, and commas are idle fill.
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary && !is_com) begin
                        data_q  <= sr_d;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StSearch;
                    com_cnt_q <= '0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Scoreboard bench for serial_byte_rx.
// For each segment, the reference model scans the whole bit stream since reset.
// It finds the comma alignment, counts aligned commas, and lists the non-comma bytes
// that are expected after lock, each with the cycle on which its strobe should appear.
module tb_serial_byte_rx;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         LOCK = 4;

    logic       CLK     = 1'b0;
    logic       RESET   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    serial_byte_rx #(
        .COM        (COM),
        .LOCK_COUNT (LOCK)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc;
    int   exp_lock = -1;
    int   drv_n = 0;
    bit   seg_bits[$];
    exp_t expq[$];
    exp_t mon_e;

    // cyc counts the edges since reset was released. Edge k samples bit k, and its result
    // is visible while cyc == k + 1.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc=%0d t=%0t)", name, got, want, cyc, $time);
        end
    endtask

    // The byte formed by stream bits k-7..k. Bits before the start of the stream are the
    // zeros left by reset.
    function automatic logic [7:0] window(input int k);
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            idx = k - 7 + i;
            w[7-i] = (idx >= 0) ? seg_bits[idx] : 1'b0;
        end
        return w;
    endfunction

    // Reference model. Only bytes that end at bit index >= old_n are new and get queued.
    task automatic model_update(input int old_n);
        int n;
        int pos;
        int k;
        int j;
        int run;
        int lock;
        n    = seg_bits.size();
        pos  = 0;
        lock = -1;
        while (lock < 0) begin
            k = pos;
            while (k < n && window(k) != COM) k++;
            if (k >= n) break;
            run = 1;
            if (run >= LOCK) begin
                lock = k;
                break;
            end
            j = k + 8;
            while (j < n) begin
                if (window(j) != COM) break;
                run++;
                if (run >= LOCK) begin
                    lock = j;
                    break;
                end
                j += 8;
            end
            if (lock >= 0 || j >= n) break;
            pos = j + 1;
        end
        exp_lock = lock;
        if (lock >= 0) begin
            for (int m = lock + 8; m < n; m += 8) begin
                if (m >= old_n && window(m) != COM) expq.push_back('{window(m), m + 1});
            end
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) seg_bits.push_back(b[i]);
    endtask

    task automatic add_rand_bits(input int n);
        for (int i = 0; i < n; i++) seg_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    // Model the newly added bits and then drive them, one per rising edge.
    // The task is entered and left on a falling edge.
    task automatic flush();
        int old;
        old = drv_n;
        model_update(old);
        for (int i = old; i < seg_bits.size(); i++) begin
            data_in = seg_bits[i];
            @(negedge CLK);
        end
        drv_n = seg_bits.size();
    endtask

    task automatic end_seg();
        #1;
        check("leftover_expected", expq.size(), 0);
    endtask

    // Close the previous segment, pulse reset, check the reset values, and release
    // reset on a falling edge.
    task automatic start_seg();
        end_seg();
        RESET = 1'b1;
        #1;
        expq.delete();
        seg_bits.delete();
        exp_lock = -1;
        drv_n    = 0;
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", valid_out, 1'b0);
        check("rst_active", active, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Monitor: checks active on every cycle, and pops the expected queue on every strobe.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                check("active", active, (exp_lock >= 0 && cyc > exp_lock));
                while (expq.size() > 0 && expq[0].t < cyc) begin
                    mon_e = expq.pop_front();
                    check("missed_strobe_cyc", 32'(cyc), 32'(mon_e.t));
                end
                if (valid_out === 1'b1) begin
                    if (expq.size() == 0) begin
                        check("unexpected_strobe", 1'b1, 1'b0);
                    end else begin
                        mon_e = expq.pop_front();
                        check("data_out", data_out, mon_e.b);
                        check("strobe_cyc", 32'(cyc), 32'(mon_e.t));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] rb;

    initial begin
        // Lock on four commas, then one data byte.
        start_seg();
        repeat (4) add_byte(COM);
        add_byte(8'h5A);
        add_byte(COM);
        flush();

        // A 3-bit random offset before alignment, and an idle comma between data bytes.
        start_seg();
        add_rand_bits(3);
        repeat (4) add_byte(COM);
        add_byte(8'hA5);
        add_byte(COM);
        add_byte(8'h3C);
        flush();

        // A non-comma byte during sync forces a new search before the receiver relocks.
        start_seg();
        add_byte(COM);
        add_byte(COM);
        add_byte(8'h77);
        repeat (4) add_byte(COM);
        add_byte(8'h11);
        flush();

        // Back-to-back data bytes give strobes 8 cycles apart.
        start_seg();
        repeat (4) add_byte(COM);
        add_byte(8'h00);
        add_byte(8'hFF);
        flush();

        // A comma pattern that straddles a byte boundary must not cause realignment.
        start_seg();
        repeat (4) add_byte(COM);
        add_byte(8'h0B);
        add_byte(8'hC0);
        flush();

        // Reset between edges in the middle of a byte clears the outputs at once, and
        // the receiver does not strobe again until it sees four new commas.
        start_seg();
        repeat (4) add_byte(COM);
        add_rand_bits(3);
        flush();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_data_out", data_out, 8'h00);
        check("async_rst_valid", valid_out, 1'b0);
        check("async_rst_active", active, 1'b0);
        start_seg();
        add_byte(8'h5A);
        add_byte(8'h3C);
        flush();

        // Random offsets, occasional interruptions during sync, and random payloads.
        for (int it = 0; it < 16; it++) begin
            start_seg();
            add_rand_bits($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                add_byte(COM);
                add_byte(8'h77);
            end
            repeat (4) add_byte(COM);
            for (int n = 0; n < 6; n++) begin
                rb = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
                add_byte(rb);
            end
            add_rand_bits($urandom_range(0, 7));
            flush();
        end

        // A raw random bit stream.
        start_seg();
        add_rand_bits(300);
        flush();

        end_seg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
